// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted request over a req/ack bus.
// Loads are lane-aligned and sign/zero-extended; misaligned requests never reach memory.
// Optional BUSY timeout abort is enabled by defining LSU_TIMEOUT_EN.
module lsu #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              inst_lb_i,
    input  logic              inst_lh_i,
    input  logic              inst_lw_i,
    input  logic              inst_lbu_i,
    input  logic              inst_lhu_i,
    input  logic              inst_sb_i,
    input  logic              inst_sh_i,
    input  logic              inst_sw_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   rs2_rd_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN/8-1:0] dmem_byte_en_o,
    output logic [XLEN-1:0]   dmem_wr_data_o,
    input  logic [XLEN-1:0]   dmem_rd_data_i,
    input  logic              dmem_ack_i,
    output logic              done_o,
    output logic              misaligned_o,
    output logic              bus_err_o,
    output logic              rd_wr_en_o,
    output logic [XLEN-1:0]   rd_wr_data_o
);

    localparam int unsigned BeW = XLEN / 8;

    if (XLEN != 32) begin : g_xlen_check
        $error("lsu: only XLEN=32 is supported");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("lsu: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        flags;
    logic              accept;
    logic              acc_half;
    logic              acc_word;
    logic              acc_misaligned;
    logic              timeout;

    // Latched request fields
    logic              byte_q, half_q, store_q, unsigned_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              misaligned_q, bus_err_q, rd_wr_en_q;
    logic [XLEN-1:0]   rd_wr_data_q;

    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_data;

    assign flags = {inst_lb_i, inst_lh_i, inst_lw_i, inst_lbu_i, inst_lhu_i,
                    inst_sb_i, inst_sh_i, inst_sw_i};

    assign accept         = (state_q == StIdle) && req_valid_i && $onehot(flags);
    assign acc_half       = inst_lh_i | inst_lhu_i | inst_sh_i;
    assign acc_word       = inst_lw_i | inst_sw_i;
    assign acc_misaligned = (acc_half & addr_i[0]) | (acc_word & (addr_i[1:0] != 2'b00));

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CntW-1:0] cnt_q;

    // Abort on the cycle that would make TIMEOUT_CYCLES BUSY cycles without ack
    assign timeout = (state_q == StBusy) && !dmem_ack_i &&
                     (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Wait counter: cleared on BUSY entry, counts BUSY cycles without ack
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == StBusy && !dmem_ack_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = acc_misaligned ? StDone : StBusy;
            StBusy: if (dmem_ack_i || timeout) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        shifted = dmem_rd_data_i >> {addr_q[1:0], 3'b000};
        if (byte_q) begin
            load_data = {{(XLEN-8){shifted[7] & ~unsigned_q}}, shifted[7:0]};
        end else if (half_q) begin
            load_data = {{(XLEN-16){shifted[15] & ~unsigned_q}}, shifted[15:0]};
        end else begin
            load_data = shifted;
        end
    end

    // Request latching and result/status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_q       <= 1'b0;
            half_q       <= 1'b0;
            store_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            rd_wr_en_q   <= 1'b0;
            rd_wr_data_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        byte_q       <= inst_lb_i | inst_lbu_i | inst_sb_i;
                        half_q       <= acc_half;
                        store_q      <= inst_sb_i | inst_sh_i | inst_sw_i;
                        unsigned_q   <= inst_lbu_i | inst_lhu_i;
                        addr_q       <= addr_i;
                        wdata_q      <= rs2_rd_data_i;
                        misaligned_q <= acc_misaligned;
                    end
                end
                StBusy: begin
                    if (dmem_ack_i) begin
                        if (!store_q) begin
                            rd_wr_data_q <= load_data;
                            rd_wr_en_q   <= 1'b1;
                        end
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                    end
                end
                StDone: begin
                    misaligned_q <= 1'b0;
                    bus_err_q    <= 1'b0;
                    rd_wr_en_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Bus outputs derive from latched fields so they stay stable while the request is held
    always_comb begin
        dmem_req_o  = (state_q == StBusy);
        dmem_we_o   = store_q;
        dmem_addr_o = {addr_q[XLEN-1:2], 2'b00};
        if (byte_q) begin
            dmem_byte_en_o = {{(BeW-1){1'b0}}, 1'b1} << addr_q[1:0];
            dmem_wr_data_o = {(XLEN/8){wdata_q[7:0]}};
        end else if (half_q) begin
            dmem_byte_en_o = {{(BeW-2){1'b0}}, 2'b11} << addr_q[1:0];
            dmem_wr_data_o = {(XLEN/16){wdata_q[15:0]}};
        end else begin
            dmem_byte_en_o = '1;
            dmem_wr_data_o = wdata_q;
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign done_o       = (state_q == StDone);
    assign misaligned_o = misaligned_q;
    assign bus_err_o    = bus_err_q;
    assign rd_wr_en_o   = rd_wr_en_q;
    assign rd_wr_data_o = rd_wr_data_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: expected completions are queued when a request is driven
// and compared when done_o appears.
module tb_lsu;

    localparam logic [7:0] F_LB  = 8'h80;
    localparam logic [7:0] F_LH  = 8'h40;
    localparam logic [7:0] F_LW  = 8'h20;
    localparam logic [7:0] F_LBU = 8'h10;
    localparam logic [7:0] F_LHU = 8'h08;
    localparam logic [7:0] F_SB  = 8'h04;
    localparam logic [7:0] F_SH  = 8'h02;
    localparam logic [7:0] F_SW  = 8'h01;

    typedef struct {
        logic        misal;
        logic        berr;
        logic        rd_en;
        logic [31:0] rd_data;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        inst_lb, inst_lh, inst_lw, inst_lbu, inst_lhu, inst_sb, inst_sh, inst_sw;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wd;
    logic [31:0] dmem_rd;
    logic        dmem_ack;
    logic        done, misaligned, bus_err, rd_wr_en;
    logic [31:0] rd_wr_data;

    exp_t        sb_q[$];
    logic [31:0] model_rd;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .inst_lb_i      (inst_lb),
        .inst_lh_i      (inst_lh),
        .inst_lw_i      (inst_lw),
        .inst_lbu_i     (inst_lbu),
        .inst_lhu_i     (inst_lhu),
        .inst_sb_i      (inst_sb),
        .inst_sh_i      (inst_sh),
        .inst_sw_i      (inst_sw),
        .addr_i         (addr),
        .rs2_rd_data_i  (rs2),
        .dmem_req_o     (dmem_req),
        .dmem_we_o      (dmem_we),
        .dmem_addr_o    (dmem_addr),
        .dmem_byte_en_o (dmem_be),
        .dmem_wr_data_o (dmem_wd),
        .dmem_rd_data_i (dmem_rd),
        .dmem_ack_i     (dmem_ack),
        .done_o         (done),
        .misaligned_o   (misaligned),
        .bus_err_o      (bus_err),
        .rd_wr_en_o     (rd_wr_en),
        .rd_wr_data_o   (rd_wr_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [7:0] fl);
        {inst_lb, inst_lh, inst_lw, inst_lbu, inst_lhu, inst_sb, inst_sh, inst_sw} = fl;
    endtask

    // Drive one request, act as memory (ack after 'waits' BUSY cycles, never if negative),
    // check the bus while held, then check the completion against the queued expectation.
    task automatic txn(input string name, input logic [7:0] fl, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] rword, input int waits,
                       input logic exp_req, input logic exp_we, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input exp_t e);
        exp_t got_e;
        int   lat;
        int   busy;
        logic seen_req;
        set_flags(fl);
        req_valid = 1'b1;
        addr      = a;
        rs2       = w;
        sb_q.push_back(e);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_idle: got %b want 1", name, req_ready);
        end
        tick;
        req_valid = 1'b0;
        set_flags(8'h00);
        addr      = ~a;
        rs2       = ~w;
        lat       = 1;
        busy      = 0;
        seen_req  = 1'b0;
        while (done !== 1'b1 && lat < 64) begin
            total++;
            if (req_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s ready_busy: got %b want 0", name, req_ready);
            end
            if (dmem_req === 1'b1) begin
                seen_req = 1'b1;
                total++;
                if ({dmem_we, dmem_addr, dmem_be, dmem_wd} !==
                    {exp_we, a[31:2], 2'b00, exp_be, exp_wd}) begin
                    bad++;
                    $display("FAIL %s bus: got we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                             name, dmem_we, dmem_addr, dmem_be, dmem_wd,
                             exp_we, {a[31:2], 2'b00}, exp_be, exp_wd);
                end
                if (busy == waits) begin
                    dmem_ack = 1'b1;
                    dmem_rd  = rword;
                end
                busy++;
            end
            tick;
            dmem_ack = 1'b0;
            dmem_rd  = 32'h5A5A_A5A5;
            lat++;
        end
        got_e = sb_q.pop_front();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s done_timeout: got no done_o want done_o", name);
        end else begin
            if ({misaligned, bus_err, rd_wr_en, rd_wr_data} !==
                {got_e.misal, got_e.berr, got_e.rd_en, got_e.rd_data}) begin
                bad++;
                $display("FAIL %s result: got mis=%b berr=%b en=%b data=%h want mis=%b berr=%b en=%b data=%h",
                         name, misaligned, bus_err, rd_wr_en, rd_wr_data,
                         got_e.misal, got_e.berr, got_e.rd_en, got_e.rd_data);
            end
            total++;
            if (lat != got_e.lat) begin
                bad++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, got_e.lat);
            end
            total++;
            if (seen_req !== exp_req) begin
                bad++;
                $display("FAIL %s req_seen: got %b want %b", name, seen_req, exp_req);
            end
            total++;
            if ({dmem_req, req_ready} !== 2'b00) begin
                bad++;
                $display("FAIL %s done_state: got req=%b ready=%b want 0 0", name, dmem_req,
                         req_ready);
            end
        end
        tick;
        total++;
        if ({done, rd_wr_en, req_ready} !== 3'b001) begin
            bad++;
            $display("FAIL %s after_done: got done=%b en=%b ready=%b want 0 0 1",
                     name, done, rd_wr_en, req_ready);
        end
    endtask

    function automatic exp_t ld_ok(input logic [31:0] d, input int lat);
        exp_t e;
        e = '{misal: 1'b0, berr: 1'b0, rd_en: 1'b1, rd_data: d, lat: lat};
        return e;
    endfunction

    function automatic exp_t no_wb(input logic mis, input logic be, input logic [31:0] d,
                                   input int lat);
        exp_t e;
        e = '{misal: mis, berr: be, rd_en: 1'b0, rd_data: d, lat: lat};
        return e;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        @(negedge clk);
        rst = 1'b0;
        tick;
        model_rd = 32'h0;
        total++;
        if ({req_ready, dmem_req, done, misaligned, bus_err, rd_wr_en, rd_wr_data} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset: got ready=%b req=%b done=%b mis=%b berr=%b en=%b data=%h want 1 0 0 0 0 0 0",
                     req_ready, dmem_req, done, misaligned, bus_err, rd_wr_en, rd_wr_data);
        end
    endtask

    task automatic test_ignore;
        req_valid = 1'b1;
        set_flags(8'h00);
        addr = 32'h40;
        tick;
        set_flags(F_LW | F_SW);
        tick;
        req_valid = 1'b0;
        set_flags(8'h00);
        total++;
        if ({req_ready, dmem_req, done} !== 3'b100) begin
            bad++;
            $display("FAIL ignore: got ready=%b req=%b done=%b want 1 0 0", req_ready, dmem_req,
                     done);
        end
    endtask

    task automatic test_loads;
        model_rd = 32'hFFFF_FF80;
        txn("lb_sign", F_LB, 32'h1003, 32'h0, 32'h80FF_1234, 0, 1'b1, 1'b0, 4'b1000, 32'h0,
            ld_ok(model_rd, 2));
        model_rd = 32'h0000_BEEF;
        txn("lhu_wait", F_LHU, 32'h2002, 32'h0, 32'hBEEF_0000, 3, 1'b1, 1'b0, 4'b1100, 32'h0,
            ld_ok(model_rd, 5));
        model_rd = 32'hFFFF_8001;
        txn("lh_sign", F_LH, 32'h0002, 32'h0, 32'h8001_0000, 1, 1'b1, 1'b0, 4'b1100, 32'h0,
            ld_ok(model_rd, 3));
        model_rd = 32'h0000_7FFF;
        txn("lh_pos", F_LH, 32'h0000, 32'h0, 32'hFFFF_7FFF, 0, 1'b1, 1'b0, 4'b0011, 32'h0,
            ld_ok(model_rd, 2));
        model_rd = 32'h0000_00F0;
        txn("lbu", F_LBU, 32'h0002, 32'h0, 32'h00F0_0000, 0, 1'b1, 1'b0, 4'b0100, 32'h0,
            ld_ok(model_rd, 2));
        model_rd = 32'hDEAD_BEEF;
        txn("lw", F_LW, 32'h0010, 32'h0, 32'hDEAD_BEEF, 2, 1'b1, 1'b0, 4'b1111, 32'h0,
            ld_ok(model_rd, 4));
    endtask

    task automatic test_stores;
        txn("sb", F_SB, 32'h0001, 32'h1234_56AB, 32'h0, 1, 1'b1, 1'b1, 4'b0010, 32'hABAB_ABAB,
            no_wb(1'b0, 1'b0, model_rd, 3));
        txn("sh", F_SH, 32'h0002, 32'hAAAA_1234, 32'h0, 0, 1'b1, 1'b1, 4'b1100, 32'h1234_1234,
            no_wb(1'b0, 1'b0, model_rd, 2));
        txn("sw", F_SW, 32'h0008, 32'hCAFE_F00D, 32'h0, 0, 1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D,
            no_wb(1'b0, 1'b0, model_rd, 2));
    endtask

    task automatic test_misaligned;
        txn("lw_mis", F_LW, 32'h0006, 32'h0, 32'h0, 0, 1'b0, 1'b0, 4'b0, 32'h0,
            no_wb(1'b1, 1'b0, model_rd, 1));
        txn("lh_mis", F_LH, 32'h0001, 32'h0, 32'h0, 0, 1'b0, 1'b0, 4'b0, 32'h0,
            no_wb(1'b1, 1'b0, model_rd, 1));
        txn("lhu_mis", F_LHU, 32'h0003, 32'h0, 32'h0, 0, 1'b0, 1'b0, 4'b0, 32'h0,
            no_wb(1'b1, 1'b0, model_rd, 1));
        txn("sw_mis", F_SW, 32'h0102, 32'h0, 32'h0, 0, 1'b0, 1'b0, 4'b0, 32'h0,
            no_wb(1'b1, 1'b0, model_rd, 1));
    endtask

    task automatic test_back_to_back;
        model_rd = 32'h0000_0011;
        txn("b2b_lbu", F_LBU, 32'h0300, 32'h0, 32'hAABB_CC11, 0, 1'b1, 1'b0, 4'b0001, 32'h0,
            ld_ok(model_rd, 2));
        txn("b2b_sb", F_SB, 32'h0303, 32'h0000_0077, 32'h0, 0, 1'b1, 1'b1, 4'b1000,
            32'h7777_7777, no_wb(1'b0, 1'b0, model_rd, 2));
        model_rd = 32'hFFFF_FFAA;
        txn("b2b_lb", F_LB, 32'h0303, 32'h0, 32'hAABB_CC11, 0, 1'b1, 1'b0, 4'b1000, 32'h0,
            ld_ok(model_rd, 2));
    endtask

    task automatic test_reset_mid_busy;
        set_flags(F_SW);
        req_valid = 1'b1;
        addr      = 32'h0000_0100;
        rs2       = 32'h0000_0055;
        tick;
        req_valid = 1'b0;
        set_flags(8'h00);
        total++;
        if (dmem_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_busy_req: got %b want 1", dmem_req);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({dmem_req, done} !== 2'b00) begin
            bad++;
            $display("FAIL rst_async: got req=%b done=%b want 0 0", dmem_req, done);
        end
        @(negedge clk);
        rst = 1'b0;
        model_rd = 32'h0;
        tick;
        total++;
        if ({req_ready, rd_wr_data} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL rst_release: got ready=%b data=%h want 1 0", req_ready, rd_wr_data);
        end
        dmem_ack = 1'b1;
        dmem_rd  = 32'h1234_5678;
        tick;
        dmem_ack = 1'b0;
        tick;
        total++;
        if ({done, dmem_req, req_ready, rd_wr_en, rd_wr_data} !== {3'b001, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL stray_ack: got done=%b req=%b ready=%b en=%b data=%h want 0 0 1 0 0",
                     done, dmem_req, req_ready, rd_wr_en, rd_wr_data);
        end
    endtask

    task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
        txn("timeout", F_LW, 32'h0020, 32'h0, 32'h1122_3344, -1, 1'b1, 1'b0, 4'b1111, 32'h0,
            no_wb(1'b0, 1'b1, model_rd, 5));
        model_rd = 32'h1122_3344;
        txn("ack_at_limit", F_LW, 32'h0020, 32'h0, 32'h1122_3344, 3, 1'b1, 1'b0, 4'b1111,
            32'h0, ld_ok(model_rd, 5));
`else
        model_rd = 32'h1122_3344;
        txn("long_wait", F_LW, 32'h0020, 32'h0, 32'h1122_3344, 6, 1'b1, 1'b0, 4'b1111, 32'h0,
            ld_ok(model_rd, 8));
`endif
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        set_flags(8'h00);
        addr      = 32'h0;
        rs2       = 32'h0;
        dmem_rd   = 32'h0;
        dmem_ack  = 1'b0;
        model_rd  = 32'h0;
        test_reset;
        test_ignore;
        test_loads;
        test_stores;
        test_misaligned;
        test_back_to_back;
        test_reset_mid_busy;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
